// File: rtl/l2_cache_victim_buffer.sv
// -----------------------------------------------------------------------------
// l2_cache_victim_buffer
//
// Purpose:
//   Holds dirty L2 victims between the LRU/fill stage and the system memory
//   writeback interface. Victims are queued in eviction order in a circular
//   FIFO and drained over a valid/ready handshake. Read misses snoop the
//   buffer so a line that has left the cache but has not yet reached memory is
//   returned from here instead of from stale memory.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   evict_en/_dirty      push a victim when both are high and the buffer is not full
//   evict_set/_tag/_data victim identity and line data
//   full                 no free slot (count == NUM_ENTRIES)
//   pending_count        number of occupied slots
//   wb_valid/wb_ready    writeback handshake for the head entry
//   wb_addr, wb_data     {tag,set} and data of the head entry
//   snoop_en/_set/_tag   lookup request
//   snoop_hit/_data      registered lookup result, one cycle after snoop_en
//
// Configuration:
//   L2_VICTIM_SNOOP_BYPASS_EN  when defined, a snoop also sees a victim that is
//                              being pushed in the same cycle (as youngest).
//   SIMULATION                 when defined, binds a checker that flags a dirty
//                              eviction attempted while full.
// -----------------------------------------------------------------------------
module l2_cache_victim_buffer #(
  parameter int NUM_ENTRIES     = 4,
  parameter int SET_INDEX_WIDTH = 8,
  parameter int TAG_WIDTH       = 18,
  parameter int DATA_WIDTH      = 512,
  parameter int COUNT_WIDTH     = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 evict_en,
  input  logic                                 evict_dirty,
  input  logic [SET_INDEX_WIDTH-1:0]           evict_set,
  input  logic [TAG_WIDTH-1:0]                 evict_tag,
  input  logic [DATA_WIDTH-1:0]                evict_data,
  output logic                                 full,
  output logic [COUNT_WIDTH-1:0]               pending_count,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [TAG_WIDTH+SET_INDEX_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]                wb_data,
  input  logic                                 snoop_en,
  input  logic [SET_INDEX_WIDTH-1:0]           snoop_set,
  input  logic [TAG_WIDTH-1:0]                 snoop_tag,
  output logic                                 snoop_hit,
  output logic [DATA_WIDTH-1:0]                snoop_data
);

  localparam int PTR_WIDTH = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [PTR_WIDTH-1:0]       head_r;
  logic [PTR_WIDTH-1:0]       tail_r;
  logic [COUNT_WIDTH-1:0]     count_r;
  logic [NUM_ENTRIES-1:0]     valid_r;
  logic [SET_INDEX_WIDTH-1:0] set_mem_r  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]       tag_mem_r  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]      data_mem_r [NUM_ENTRIES];
  logic                       snoop_hit_r;
  logic [DATA_WIDTH-1:0]      snoop_data_r;

  logic                       full_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       snoop_hit_s;
  logic [DATA_WIDTH-1:0]      snoop_data_s;

  assign full_s = (count_r == COUNT_WIDTH'(NUM_ENTRIES));
  // A push while full is dropped, even if the head pops in the same cycle.
  assign push_s = evict_en & evict_dirty & ~full_s;
  assign pop_s  = (count_r != {COUNT_WIDTH{1'b0}}) & wb_ready;

  assign full          = full_s;
  assign pending_count = count_r;
  assign wb_valid      = (count_r != {COUNT_WIDTH{1'b0}});
  assign wb_addr       = {tag_mem_r[head_r], set_mem_r[head_r]};
  assign wb_data       = data_mem_r[head_r];
  assign snoop_hit     = snoop_hit_r;
  assign snoop_data    = snoop_data_r;

  // Snoop match: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx_s;
    logic                 match_s;
    snoop_hit_s  = 1'b0;
    snoop_data_s = {DATA_WIDTH{1'b0}};
    idx_s        = {PTR_WIDTH{1'b0}};
    match_s      = 1'b0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      idx_s        = head_r + PTR_WIDTH'(k);
      // valid_r reflects the start of the cycle, so an entry popping now still matches.
      match_s      = valid_r[idx_s] && (set_mem_r[idx_s] == snoop_set) &&
                     (tag_mem_r[idx_s] == snoop_tag);
      snoop_hit_s  = snoop_hit_s | match_s;
      snoop_data_s = match_s ? data_mem_r[idx_s] : snoop_data_s;
    end
`ifdef L2_VICTIM_SNOOP_BYPASS_EN
    // The victim being pushed this cycle is younger than anything stored.
    match_s      = push_s && (evict_set == snoop_set) && (evict_tag == snoop_tag);
    snoop_hit_s  = snoop_hit_s | match_s;
    snoop_data_s = match_s ? evict_data : snoop_data_s;
`endif
  end

  // FIFO control state: pointers, occupancy, valid bits and the snoop hit flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r      <= {PTR_WIDTH{1'b0}};
      tail_r      <= {PTR_WIDTH{1'b0}};
      count_r     <= {COUNT_WIDTH{1'b0}};
      valid_r     <= {NUM_ENTRIES{1'b0}};
      snoop_hit_r <= 1'b0;
    end else begin
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      snoop_hit_r <= snoop_en & snoop_hit_s;
    end
  end

  // Entry payload and snoop data; not reset, only qualified by valid bits / snoop_hit.
  always_ff @(posedge clk) begin
    if (push_s) begin
      set_mem_r[tail_r]  <= evict_set;
      tag_mem_r[tail_r]  <= evict_tag;
      data_mem_r[tail_r] <= evict_data;
    end
    if (snoop_en && snoop_hit_s) begin
      snoop_data_r <= snoop_data_s;
    end
  end

`ifdef SIMULATION
  l2_cache_victim_buffer_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .evict_en    (evict_en),
    .evict_dirty (evict_dirty),
    .full        (full_s)
  );
`endif

endmodule

`ifdef SIMULATION
// Checker: the fill stage must never issue a dirty eviction while the buffer is full.
module l2_cache_victim_buffer_chk (
  input logic clk,
  input logic reset,
  input logic evict_en,
  input logic evict_dirty,
  input logic full
);
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (reset) !(evict_en && evict_dirty && full)
  ) else $error("victim buffer: dirty eviction dropped while full");
endmodule
`endif

// File: tb/tb_l2_cache_victim_buffer.sv
// -----------------------------------------------------------------------------
// tb_l2_cache_victim_buffer
//
// Purpose:
//   Self-checking bench for l2_cache_victim_buffer (default parameters).
//   A table of one-cycle vectors drives the FIFO through push, hold, fill,
//   drop-when-full, drain, snoop and push+pop cases; hand-written sequences
//   cover reset mid-drain and the same-cycle push/snoop behaviour, whose
//   expectation follows L2_VICTIM_SNOOP_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_l2_cache_victim_buffer;

  localparam int SW = 8;
  localparam int TW = 18;
  localparam int DW = 512;
  localparam int CW = 3;

  typedef struct packed {
    logic          e_en;
    logic          e_dirty;
    logic [SW-1:0] e_set;
    logic [TW-1:0] e_tag;
    logic [7:0]    e_seed;
    logic          rdy;
    logic          s_en;
    logic [SW-1:0] s_set;
    logic [TW-1:0] s_tag;
    logic          x_wbv;
    logic          x_full;
    logic [CW-1:0] x_cnt;
    logic [TW-1:0] x_tag;
    logic [SW-1:0] x_set;
    logic [7:0]    x_seed;
    logic          x_hit;
    logic [7:0]    x_sseed;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             evict_en;
  logic             evict_dirty;
  logic [SW-1:0]    evict_set;
  logic [TW-1:0]    evict_tag;
  logic [DW-1:0]    evict_data;
  logic             full;
  logic [CW-1:0]    pending_count;
  logic             wb_valid;
  logic             wb_ready;
  logic [TW+SW-1:0] wb_addr;
  logic [DW-1:0]    wb_data;
  logic             snoop_en;
  logic [SW-1:0]    snoop_set;
  logic [TW-1:0]    snoop_tag;
  logic             snoop_hit;
  logic [DW-1:0]    snoop_data;

  int   n_total;
  int   n_pass;
  vec_t vecs[$];

  l2_cache_victim_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .evict_en      (evict_en),
    .evict_dirty   (evict_dirty),
    .evict_set     (evict_set),
    .evict_tag     (evict_tag),
    .evict_data    (evict_data),
    .full          (full),
    .pending_count (pending_count),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .snoop_en      (snoop_en),
    .snoop_set     (snoop_set),
    .snoop_tag     (snoop_tag),
    .snoop_hit     (snoop_hit),
    .snoop_data    (snoop_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_of(input logic [7:0] seed);
    return {64{seed}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic ee, input logic ed, input logic [SW-1:0] es,
                     input logic [TW-1:0] et, input logic [7:0] eseed, input logic rdy,
                     input logic se, input logic [SW-1:0] ss, input logic [TW-1:0] st,
                     input logic xw, input logic xf, input logic [CW-1:0] xc,
                     input logic [TW-1:0] xt, input logic [SW-1:0] xs, input logic [7:0] xd,
                     input logic xh, input logic [7:0] xsd);
    vec_t v;
    v = '{ee, ed, es, et, eseed, rdy, se, ss, st, xw, xf, xc, xt, xs, xd, xh, xsd};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    evict_en = 1'b0; evict_dirty = 1'b0; evict_set = '0; evict_tag = '0;
    evict_data = '0; wb_ready = 1'b0; snoop_en = 1'b0; snoop_set = '0; snoop_tag = '0;
  endtask

  // Inputs are applied just after an edge, outputs sampled 1 time unit after the next.
  task automatic run_vec(input vec_t v, input int n);
    evict_en = v.e_en; evict_dirty = v.e_dirty; evict_set = v.e_set;
    evict_tag = v.e_tag; evict_data = line_of(v.e_seed); wb_ready = v.rdy;
    snoop_en = v.s_en; snoop_set = v.s_set; snoop_tag = v.s_tag;
    @(posedge clk); #1;
    chk($sformatf("v%0d_wb_valid", n), DW'(wb_valid), DW'(v.x_wbv));
    chk($sformatf("v%0d_full", n), DW'(full), DW'(v.x_full));
    chk($sformatf("v%0d_count", n), DW'(pending_count), DW'(v.x_cnt));
    chk($sformatf("v%0d_snoop_hit", n), DW'(snoop_hit), DW'(v.x_hit));
    if (v.x_wbv) begin
      chk($sformatf("v%0d_wb_addr", n), DW'(wb_addr), DW'({v.x_tag, v.x_set}));
      chk($sformatf("v%0d_wb_data", n), wb_data, line_of(v.x_seed));
    end
    if (v.x_hit) chk($sformatf("v%0d_snoop_data", n), snoop_data, line_of(v.x_sseed));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", DW'(wb_valid), DW'(1'b0));
    chk("rst_full", DW'(full), DW'(1'b0));
    chk("rst_count", DW'(pending_count), DW'(3'd0));
    chk("rst_snoop_hit", DW'(snoop_hit), DW'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    //   en dty set    tag        seed   rdy sen sset   stag      wbv ful cnt  xtag       xset   xseed  hit sseed
    add(0, 0, 8'h00, 18'h00000, 8'h00, 0, 0, 8'h00, 18'h00000, 0, 0, 3'd0, 18'h00000, 8'h00, 8'h00, 0, 8'h00);
    add(1, 0, 8'h01, 18'h00001, 8'h55, 0, 0, 8'h00, 18'h00000, 0, 0, 3'd0, 18'h00000, 8'h00, 8'h00, 0, 8'h00);
    add(1, 1, 8'h12, 18'h003A5, 8'hD0, 0, 0, 8'h00, 18'h00000, 1, 0, 3'd1, 18'h003A5, 8'h12, 8'hD0, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      add(0, 0, 8'h00, 18'h00000, 8'h00, 0, 0, 8'h00, 18'h00000, 1, 0, 3'd1, 18'h003A5, 8'h12, 8'hD0, 0, 8'h00);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 1, 0, 8'h00, 18'h00000, 0, 0, 3'd0, 18'h00000, 8'h00, 8'h00, 0, 8'h00);
    // fill four victims, then a fifth push while full is dropped
    for (int i = 1; i <= 4; i++)
      add(1, 1, 8'(i), 18'(16 + i), 8'(8'hA0 + i), 0, 0, 8'h00, 18'h00000,
          1, (i == 4), 3'(i), 18'h00011, 8'h01, 8'hA1, 0, 8'h00);
    add(1, 1, 8'h05, 18'h00015, 8'hA5, 0, 0, 8'h00, 18'h00000, 1, 1, 3'd4, 18'h00011, 8'h01, 8'hA1, 0, 8'h00);
    // drain in push order
    for (int i = 2; i <= 4; i++)
      add(0, 0, 8'h00, 18'h00000, 8'h00, 1, 0, 8'h00, 18'h00000,
          1, 0, 3'(5 - i), 18'(16 + i), 8'(i), 8'(8'hA0 + i), 0, 8'h00);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 1, 0, 8'h00, 18'h00000, 0, 0, 3'd0, 18'h00000, 8'h00, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 1, 0, 8'h00, 18'h00000, 0, 0, 3'd0, 18'h00000, 8'h00, 8'h00, 0, 8'h00);
    // same line evicted twice; snoop returns the younger copy
    add(1, 1, 8'h05, 18'h00007, 8'hE1, 0, 0, 8'h00, 18'h00000, 1, 0, 3'd1, 18'h00007, 8'h05, 8'hE1, 0, 8'h00);
    add(1, 1, 8'h05, 18'h00007, 8'hE2, 0, 0, 8'h00, 18'h00000, 1, 0, 3'd2, 18'h00007, 8'h05, 8'hE1, 0, 8'h00);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 0, 1, 8'h05, 18'h00007, 1, 0, 3'd2, 18'h00007, 8'h05, 8'hE1, 1, 8'hE2);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 0, 1, 8'h05, 18'h00008, 1, 0, 3'd2, 18'h00007, 8'h05, 8'hE1, 0, 8'h00);
    // push and pop together at count 2, then snoop an entry as it pops
    add(1, 1, 8'h06, 18'h00009, 8'hC1, 1, 0, 8'h00, 18'h00000, 1, 0, 3'd2, 18'h00007, 8'h05, 8'hE2, 0, 8'h00);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 1, 1, 8'h05, 18'h00007, 1, 0, 3'd1, 18'h00009, 8'h06, 8'hC1, 1, 8'hE2);
    add(0, 0, 8'h00, 18'h00000, 8'h00, 0, 0, 8'h00, 18'h00000, 1, 0, 3'd1, 18'h00009, 8'h06, 8'hC1, 0, 8'h00);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // reset mid-drain: outputs clear immediately, nothing survives release
    idle_inputs();
    evict_en = 1'b1; evict_dirty = 1'b1; evict_set = 8'h20; evict_tag = 18'h00021;
    evict_data = line_of(8'hB1);
    @(posedge clk); #1;
    chk("pre_rst_count", DW'(pending_count), DW'(3'd2));
    idle_inputs();
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_drain_count", DW'(pending_count), DW'(3'd1));
    chk("mid_drain_addr", DW'(wb_addr), DW'({18'h00021, 8'h20}));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wb_valid", DW'(wb_valid), DW'(1'b0));
    chk("async_rst_full", DW'(full), DW'(1'b0));
    chk("async_rst_count", DW'(pending_count), DW'(3'd0));
    chk("async_rst_snoop_hit", DW'(snoop_hit), DW'(1'b0));
    wb_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_wb_valid", DW'(wb_valid), DW'(1'b0));
    chk("post_rst_count", DW'(pending_count), DW'(3'd0));

    // same-cycle push and snoop of the same line
    evict_en = 1'b1; evict_dirty = 1'b1; evict_set = 8'h03; evict_tag = 18'h00009;
    evict_data = line_of(8'hD3);
    snoop_en = 1'b1; snoop_set = 8'h03; snoop_tag = 18'h00009;
    @(posedge clk); #1;
    chk("bypass_count", DW'(pending_count), DW'(3'd1));
`ifdef L2_VICTIM_SNOOP_BYPASS_EN
    chk("bypass_snoop_hit", DW'(snoop_hit), DW'(1'b1));
    chk("bypass_snoop_data", snoop_data, line_of(8'hD3));
`else
    chk("bypass_snoop_hit", DW'(snoop_hit), DW'(1'b0));
`endif
    evict_en = 1'b0; evict_dirty = 1'b0;
    @(posedge clk); #1;
    chk("stored_snoop_hit", DW'(snoop_hit), DW'(1'b1));
    chk("stored_snoop_data", snoop_data, line_of(8'hD3));
    snoop_en = 1'b0;
    @(posedge clk); #1;
    chk("snoop_off_hit", DW'(snoop_hit), DW'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
